// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states
// and the request legality rule.
package alu_pkg;

  localparam logic [4:0] ALU_OP_NOP  = 5'b00000;
  localparam logic [4:0] ALU_OP_SADD = 5'b00001;
  localparam logic [4:0] ALU_OP_UADD = 5'b00010;
  localparam logic [4:0] ALU_OP_SUB  = 5'b00011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS0 = 3'd1,
    ST_PASS1 = 3'd2,
    ST_PASS2 = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

  // Wide requests only support unsigned add; narrow requests take any of the
  // three arithmetic opcodes.
  function automatic logic op_legal(input logic [4:0] op, input logic wide);
    logic ok;
    ok = 1'b0;
    if (wide) begin
      ok = (op == ALU_OP_UADD);
    end else begin
      ok = (op == ALU_OP_SADD) || (op == ALU_OP_UADD) || (op == ALU_OP_SUB);
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Registered initiator for the combinational N-bit ALU. Narrow requests take
// one ALU pass; 2N-bit unsigned adds take three passes so the low-half carry
// can be folded into the high half without a carry-in on the ALU.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE; rsp_valid is high only in
// RESP, and every rsp_* output holds steady until rsp_ready is seen.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic             req_wide,
  input  logic [2*N-1:0]   req_a,
  input  logic [2*N-1:0]   req_b,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [4:0]       alu_op,
  input  logic [N-1:0]     alu_sum,
  input  logic             alu_cout,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_result,
  output logic             rsp_cout,
  output logic             rsp_neg,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_err
);

  seq_state_t     state;
  seq_state_t     state_next;
  logic           wide_q;
  logic [N-1:0]   a_hi;
  logic [N-1:0]   b_hi;
  logic           c0;
  logic           c1;
  logic           accept;
  logic           legal;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign legal     = op_legal(req_op, req_wide);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one cycle per ALU pass, then wait in RESP for the consumer.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (accept) state_next = legal ? ST_PASS0 : ST_RESP;
      ST_PASS0: state_next = wide_q ? ST_PASS1 : ST_RESP;
      ST_PASS1: state_next = ST_PASS2;
      ST_PASS2: state_next = ST_RESP;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: load the ALU drive for the coming pass and capture the result of
  // the pass just finished. alu_* are registers so the ALU sees clean inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wide_q     <= 1'b0;
      a_hi       <= '0;
      b_hi       <= '0;
      c0         <= 1'b0;
      c1         <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= ALU_OP_NOP;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            wide_q     <= req_wide;
            a_hi       <= req_a[2*N-1:N];
            b_hi       <= req_b[2*N-1:N];
            c0         <= 1'b0;
            c1         <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= !legal;
            if (legal) begin
              alu_a  <= req_a[N-1:0];
              alu_b  <= req_b[N-1:0];
              alu_op <= req_op;
            end
          end
        end
        ST_PASS0: begin
          if (wide_q) begin
            // Low half done; keep carry c0 for the third pass.
            rsp_result[N-1:0] <= alu_sum;
            c0                <= alu_cout;
            alu_a             <= a_hi;
            alu_b             <= b_hi;
          end else begin
            rsp_result <= {{N{1'b0}}, alu_sum};
            rsp_cout   <= alu_cout;
            rsp_neg    <= alu_neg;
            rsp_ovf    <= alu_ovf;
            rsp_zero   <= alu_zero;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= ALU_OP_NOP;
          end
        end
        ST_PASS1: begin
          // alu_a now carries hi1; the third pass adds c0 into it.
          c1    <= alu_cout;
          alu_a <= alu_sum;
          alu_b <= {{(N-1){1'b0}}, c0};
        end
        ST_PASS2: begin
          rsp_result[2*N-1:N] <= alu_sum;
          rsp_cout            <= c1 | alu_cout;
          rsp_ovf             <= c1 | alu_cout;
          rsp_neg             <= 1'b0;
          rsp_zero            <= (alu_sum == '0) && (rsp_result[N-1:0] == '0);
          rsp_err             <= 1'b0;
          alu_a               <= '0;
          alu_b               <= '0;
          alu_op              <= ALU_OP_NOP;
        end
        default: begin
          // RESP: hold everything until the consumer takes the response.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model attached
// to the alu_* ports and a queue-based scoreboard on the response side.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N  = 32;
  localparam int EW = 2*N + 5 + 3 + 2;

  typedef struct packed {
    logic [2*N-1:0] res;
    logic           cout;
    logic           neg;
    logic           ovf;
    logic           zero;
    logic           err;
    logic [2:0]     lat;
    logic [1:0]     passes;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [4:0]     req_op;
  logic           req_wide;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [4:0]     alu_op;
  logic [N-1:0]   alu_sum;
  logic           alu_cout;
  logic           alu_neg;
  logic           alu_ovf;
  logic           alu_zero;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*N-1:0] rsp_result;
  logic           rsp_cout;
  logic           rsp_neg;
  logic           rsp_ovf;
  logic           rsp_zero;
  logic           rsp_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  alu_op_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_wide(req_wide), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sum(alu_sum), .alu_cout(alu_cout), .alu_neg(alu_neg),
    .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: add / unsigned add / subtract with carry and flags.
  always_comb begin
    logic [N:0] ext;
    ext = '0;
    if (alu_op == ALU_OP_SADD || alu_op == ALU_OP_UADD) ext = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == ALU_OP_SUB) ext = {1'b0, alu_a} + {1'b0, ~alu_b} + 1;
    alu_sum  = ext[N-1:0];
    alu_cout = ext[N];
    alu_neg  = ext[N-1];
    alu_zero = (ext[N-1:0] == '0);
    alu_ovf  = 1'b0;
    if (alu_op == ALU_OP_SADD) alu_ovf = (alu_a[N-1] == alu_b[N-1]) && (ext[N-1] != alu_a[N-1]);
    else if (alu_op == ALU_OP_UADD) alu_ovf = ext[N];
    else if (alu_op == ALU_OP_SUB) alu_ovf = (alu_a[N-1] != alu_b[N-1]) && (ext[N-1] != alu_a[N-1]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on the first cycle of each response and
  // re-checks every held cycle, so back-pressure stability is covered too.
  logic active      = 1'b0;
  logic expect_idle = 1'b0;
  exp_t cur;
  int   pass_cnt    = 0;
  int   uadd_cnt    = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active      = 1'b0;
      expect_idle = 1'b0;
      pass_cnt    = 0;
      uadd_cnt    = 0;
    end else begin
      if (expect_idle) begin
        check("req_ready after release", {63'd0, req_ready}, 64'd1);
        check("rsp_valid after release", {63'd0, rsp_valid}, 64'd0);
        expect_idle = 1'b0;
      end
      if (alu_op != ALU_OP_NOP) begin
        pass_cnt++;
        if (alu_op == ALU_OP_UADD) uadd_cnt++;
      end
      if (rsp_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("unexpected rsp_valid", {63'd0, rsp_valid}, 64'd0);
          end else begin
            cur = exp_t'(exp_q.pop_front());
            check("latency", 64'(cyc - acc_q.pop_front() + 1), 64'(cur.lat));
            check("alu pass count", 64'(pass_cnt), 64'(cur.passes));
            if (cur.passes == 2'd3) check("wide passes use uadd", 64'(uadd_cnt), 64'd3);
            active = 1'b1;
          end
        end
        if (active) begin
          check("rsp_result", rsp_result, cur.res);
          check("rsp_cout", {63'd0, rsp_cout}, {63'd0, cur.cout});
          check("rsp_neg", {63'd0, rsp_neg}, {63'd0, cur.neg});
          check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, cur.ovf});
          check("rsp_zero", {63'd0, rsp_zero}, {63'd0, cur.zero});
          check("rsp_err", {63'd0, rsp_err}, {63'd0, cur.err});
          check("req_ready in resp", {63'd0, req_ready}, 64'd0);
          check("alu_op in resp", {59'd0, alu_op}, {59'd0, ALU_OP_NOP});
          if (rsp_ready) begin
            active      = 1'b0;
            expect_idle = 1'b1;
            pass_cnt    = 0;
            uadd_cnt    = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Driver: issue one request, push its expectation, optionally hold off the
  // response for 'hold' cycles, then wait for the response to be consumed.
  task automatic send(input logic [4:0] op, input logic wide,
                      input logic [2*N-1:0] a, input logic [2*N-1:0] b,
                      input logic [2*N-1:0] res, input logic cout, input logic neg,
                      input logic ovf, input logic zero, input logic err,
                      input logic [2:0] lat, input logic [1:0] passes, input int hold);
    int   t;
    int   start;
    exp_t e;
    start     = done_cnt;
    req_op    = op;
    req_wide  = wide;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("request accept timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e = '{res: res, cout: cout, neg: neg, ovf: ovf, zero: zero, err: err,
          lat: lat, passes: passes};
    exp_q.push_back(EW'(e));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = ALU_OP_NOP;
    req_wide  = 1'b0;
    if (hold > 0) begin
      t = 0;
      while (!rsp_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      repeat (hold) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    t = 0;
    while (done_cnt == start && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == start) check("response timeout", 64'(done_cnt), 64'(start + 1));
    @(negedge clk);
  endtask

  // Main sequence.
  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = ALU_OP_NOP;
    req_wide  = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", {63'd0, req_ready}, 64'd1);
    check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset rsp_result", rsp_result, 64'd0);
    check("reset rsp flags", {59'd0, rsp_cout, rsp_neg, rsp_ovf, rsp_zero, rsp_err}, 64'd0);
    check("reset alu drive", {alu_a, alu_b} | {59'd0, alu_op}, 64'd0);

    // op, wide, a, b, result, cout, neg, ovf, zero, err, latency, passes, hold
    send(ALU_OP_UADD, 1'b0, 64'hFFFF_FFFF, 64'h1, 64'h0, 1, 0, 1, 1, 0, 3'd2, 2'd1, 0);
    send(ALU_OP_SUB,  1'b0, 64'h5, 64'h7, 64'h0000_0000_FFFF_FFFE, 0, 1, 0, 0, 0, 3'd2, 2'd1, 0);
    send(ALU_OP_SADD, 1'b0, 64'h7FFF_FFFF, 64'h1, 64'h0000_0000_8000_0000, 0, 1, 1, 0, 0, 3'd2, 2'd1, 0);
    send(ALU_OP_UADD, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'h1, 64'h0000_0002_0000_0000, 0, 0, 0, 0, 0, 3'd4, 2'd3, 0);
    send(ALU_OP_UADD, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0, 1, 1, 0, 3'd4, 2'd3, 0);
    send(5'b00111,    1'b0, 64'h1234, 64'h5678, 64'h0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0);
    send(ALU_OP_SUB,  1'b1, 64'h9, 64'h2, 64'h0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0);
    send(ALU_OP_SADD, 1'b0, 64'h2, 64'h3, 64'h5, 0, 0, 0, 0, 0, 3'd2, 2'd1, 3);
    send(ALU_OP_UADD, 1'b1, 64'hAAAA_AAAA_0000_0001, 64'h1111_1111_0000_0002, 64'hBBBB_BBBB_0000_0003, 0, 0, 0, 0, 0, 3'd4, 2'd3, 2);

    // Abort a wide request in PASS1 with reset; no response may follow.
    req_op    = ALU_OP_UADD;
    req_wide  = 1'b1;
    req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b     = 64'h1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("alu_op in wide pass1", {59'd0, alu_op}, {59'd0, ALU_OP_UADD});
    check("alu_a in wide pass1", {32'd0, alu_a}, 64'hFFFF_FFFF);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("req_ready after abort", {63'd0, req_ready}, 64'd1);
    check("alu_op after abort", {59'd0, alu_op}, {59'd0, ALU_OP_NOP});
    repeat (5) begin
      check("rsp_valid after abort", {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
    end
    send(ALU_OP_UADD, 1'b0, 64'h2, 64'h3, 64'h5, 0, 0, 0, 0, 0, 3'd2, 2'd1, 0);

    check("leftover expectations", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Registered initiator for the team's combinational carry-select adder/ALU. It accepts operation requests over a valid/ready handshake and drives the ALU operand/opcode ports. It samples the ALU sum and flags, then returns a registered response over a second valid/ready handshake. It also performs 2N-bit unsigned adds by running the N-bit ALU for three passes, which chains the carry that the ALU cannot accept as an input.

Parameters:
N, 32, ALU datapath width; wide requests are 2N bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept (high only in IDLE)
req_op  input  5  ALU opcode: 00001 signed add, 00010 unsigned add, 00011 subtract
req_wide  input  1  1 = 2N-bit unsigned add
req_a  input  2N  operand A (narrow uses [N-1:0])
req_b  input  2N  operand B (narrow uses [N-1:0])
alu_a  output  N  to ALU a
alu_b  output  N  to ALU b
alu_op  output  5  to ALU aluop
alu_sum  input  N  from ALU final_sum
alu_cout  input  1  from ALU cout
alu_neg  input  1  from ALU negative_flag
alu_ovf  input  1  from ALU overflow_flag
alu_zero  input  1  from ALU zero_flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  2N  result (narrow: zero-extended)
rsp_cout  output  1  carry out
rsp_neg  output  1  negative flag
rsp_ovf  output  1  overflow flag
rsp_zero  output  1  zero flag
rsp_err  output  1  request rejected (illegal op, or wide with op other than 00010)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All rsp_* outputs are 0, alu_a/alu_b are 0, alu_op is 00000, and req_ready is 1 on the cycle after reset.
- States: IDLE, PASS0, PASS1, PASS2, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op, wide, a and b.
  - Illegal request -> RESP with rsp_err=1; result and all flags 0.
  - Narrow request -> PASS0.
  - Wide request -> PASS0.
- ALU drive: alu_* are driven from internal registers only. In IDLE and RESP they are 0/0/00000. The ALU is combinational, so each pass occupies exactly one cycle, and alu_* outputs are sampled at the end of that cycle.
- Narrow PASS0: drive a[N-1:0], b[N-1:0], op. Capture rsp_result = {N'0, alu_sum}; copy cout, neg, ovf and zero verbatim from the ALU. Go to RESP.
- Wide PASS0: drive a_lo, b_lo, op 00010. Store lo=alu_sum and c0=alu_cout.
- Wide PASS1: drive a_hi, b_hi, op 00010. Store hi1=alu_sum and c1=alu_cout.
- Wide PASS2: drive hi1 and {N-1'0, c0}, op 00010. Store hi=alu_sum and c2=alu_cout.
- Wide result and flags: rsp_result={hi,lo}; rsp_cout=c1|c2; rsp_ovf=rsp_cout; rsp_neg=0; rsp_zero=(hi==0)&&(lo==0); rsp_err=0.
- RESP: rsp_valid=1, with all rsp_* held stable until rsp_ready=1. On that edge, go to IDLE and deassert rsp_valid. There is no response/request overlap: a new request is accepted only in IDLE, one cycle after the handshake.
- Latency from the accept edge to rsp_valid high:
  - narrow: 2 cycles;
  - wide: 4 cycles;
  - error: 1 cycle.
- Requests with req_valid high while req_ready is low are ignored; the requester holds them.
- Reset mid-operation (any state) aborts the operation. No response is issued, and partial results are discarded.
- rsp_ready high outside RESP has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams ALU_OP_SADD=5'b00001, ALU_OP_UADD=5'b00010, ALU_OP_SUB=5'b00011, ALU_OP_NOP=5'b00000;
  - the sequencer state enum.
- No sub-module. The ALU instance lives in the parent and connects to the alu_* ports, which keeps the sequencer testable against a behavioural ALU model.

Test Plan:
- Narrow unsigned add: a=0xFFFF_FFFF, b=1, op 00010 -> rsp_result=0, cout=1, ovf=1, zero=1; rsp_valid exactly 2 cycles after accept.
- Narrow subtract: a=5, b=7, op 00011 -> rsp_result[31:0]=0xFFFF_FFFE, upper word 0, err=0.
- Wide carry chain: a=0x00000001_FFFFFFFF, b=1, wide=1 -> result=0x00000002_00000000, cout=0, zero=0; rsp_valid 4 cycles after accept. The bench checks alu_op=00010 on every pass.
- Wide full wrap: a=0xFFFFFFFF_FFFFFFFF, b=1 -> result=0, cout=1, ovf=1, zero=1, neg=0.
- Errors and back-pressure:
  - op 00111 -> err=1, result 0 after 1 cycle;
  - wide with op 00011 -> err=1;
  - hold rsp_ready low 3 cycles -> outputs stable and req_ready low; release -> IDLE on the next cycle.
- Reset in PASS1 of a wide request -> rsp_valid stays 0 and req_ready is 1 next cycle. A following narrow 2+3 op 00010 then returns 5.
